cnt_8: RTL and testbench
========================

CNT_8 -- requirements
Module: cnt_8

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 8, the counter width in bits; legal values are multiples of 4, from 4 to 32.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port ci, input, 1 bit: carry-in / count enable.
REQ-005 The module SHALL have port co, output, 1 bit: carry-out, used for cascading.
REQ-006 The module SHALL have port q, output, WIDTH bits: the current count value, unsigned.

Function
REQ-007 On each rising clk edge with rst low and ci=1, q SHALL become (q+1) mod 2^WIDTH.
REQ-008 On each rising clk edge with rst low and ci=0, q SHALL hold its value.
REQ-009 q SHALL be a registered output; the new value is visible one clk edge after ci is sampled, with no other latency.
REQ-010 co SHALL be combinational: co = ci AND (q == all-ones). With WIDTH=8, co=1 exactly when ci=1 and q=8'hFF.
REQ-011 Wrap-around: when q=all-ones and ci=1, the next edge SHALL give q=0; co is 1 during the cycle before the wrap and 0 after it (unless ci and all-ones occur again).
REQ-012 co SHALL follow ci changes within the same cycle, with no register; ci=0 forces co=0 whatever the value of q.
REQ-013 Cascading: connecting co of stage N to ci of stage N+1, on the same clk and rst, SHALL form a correct WIDTH*k-bit synchronous counter.
REQ-014 ci is sampled only at rising clk edges; glitches on ci between edges SHALL NOT change q.
REQ-015 There SHALL be no load, no down-count and no saturation mode.

Reset
REQ-016 rst=1 SHALL force q=0 immediately, independent of clk, and SHALL hold q=0 while rst stays high.
REQ-017 While rst=1, co SHALL equal 0 (q=0 is not all-ones for any WIDTH >= 1).
REQ-018 On release of rst, counting SHALL resume at the first rising clk edge at which rst is low; the first count gives q=1 if ci=1.
REQ-019 A reset asserted in the middle of a count SHALL discard the count in progress; there SHALL be no partial update.

Structure
REQ-020 The counter SHALL be built from WIDTH/4 instances of one sub-module, cnt4_slice (a 4-bit counter with ports clk, rst, ci, co, q[3:0]), chained ripple-wise from co to ci.
REQ-021 The all-ones test in each slice SHALL be local to that slice; the top-level co SHALL be the co of the last slice.
REQ-022 A shared package cnt_pkg SHALL hold the SLICE_W=4 constant and the default WIDTH; the block needs no typedefs.
REQ-023 The design SHALL be fully synchronous apart from the asynchronous reset, with no latches.

Verification
REQ-024 The bench SHALL assert rst=1 at t=0 while clk is running, then check q=8'h00 and co=0 at once, before any clk edge.
REQ-025 The bench SHALL release rst, hold ci=1 for 5 rising edges, and check q steps 1,2,3,4,5 with co=0 throughout.
REQ-026 The bench SHALL drop ci to 0 for one edge, check q holds its value, then restore ci=1 and check counting resumes at +1.
REQ-027 The bench SHALL preset q to 8'hFE by counting, keep ci=1, and check: q=8'hFF with co=1; at the next edge q=8'h00 with co=0.
REQ-028 With q=8'hFF, the bench SHALL toggle ci 1→0→1 with no clk edge, and check co goes 1→0→1 combinationally while q stays 8'hFF.
REQ-029 The bench SHALL assert rst mid-count at q=8'h37, between clk edges, and check q=0 at once; after rst falls with ci=1, the first edge gives q=1.

Source files
------------

// File: rtl/cnt_pkg.sv
// Shared constants for the sliced up-counter: slice width, default counter width
// and the per-slice increment/all-ones helpers.
package cnt_pkg;

  localparam int SLICE_W       = 4;
  localparam int DEFAULT_WIDTH = 8;

  localparam logic [SLICE_W-1:0] SLICE_ZERO = 4'h0;
  localparam logic [SLICE_W-1:0] SLICE_ONES = 4'hF;

  function automatic logic [SLICE_W-1:0] slice_inc(input logic [SLICE_W-1:0] v);
    return v + 4'd1;
  endfunction

  function automatic logic slice_full(input logic [SLICE_W-1:0] v);
    return (v == SLICE_ONES);
  endfunction

endpackage

// File: rtl/cnt4_slice.sv
// 4-bit synchronous counter slice with combinational carry-out for ripple cascading.
module cnt4_slice
  import cnt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ci,
  output logic               co,
  output logic [SLICE_W-1:0] q
);

  logic [SLICE_W-1:0] q_r;
  logic               full_s;

  // count register: clears asynchronously, increments when carry-in is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= SLICE_ZERO;
    end else if (ci) begin
      q_r <= slice_inc(q_r);
    end else begin
      q_r <= q_r;
    end
  end

  // carry-out is a pure gate so a chain of slices counts in one cycle
  always_comb begin
    full_s = slice_full(q_r);
    co     = ci & full_s;
  end

  assign q = q_r;

endmodule

// File: rtl/cnt_8.sv
// WIDTH-bit synchronous up-counter built from a ripple chain of 4-bit slices;
// co is ci AND (q == all-ones), taken from the last slice.
module cnt_8
  import cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ci,
  output logic             co,
  output logic [WIDTH-1:0] q
);

  localparam int NUM_SLICES = WIDTH / SLICE_W;

  logic [NUM_SLICES:0] carry_s;

  assign carry_s[0] = ci;

  for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
    cnt4_slice u_slice (
      .clk (clk),
      .rst (rst),
      .ci  (carry_s[i]),
      .co  (carry_s[i+1]),
      .q   (q[i*SLICE_W +: SLICE_W])
    );
  end

  assign co = carry_s[NUM_SLICES];

endmodule

// File: tb/tb_cnt_8.sv
// Directed self-checking bench for cnt_8 (WIDTH=8): reset, count, hold,
// wrap, combinational co, ci glitch immunity and mid-count reset.
module tb_cnt_8;

  logic       clk;
  logic       rst;
  logic       ci;
  logic       co;
  logic [7:0] q;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q;

  cnt_8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .ci  (ci),
    .co  (co),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // one rising edge, then land on the falling edge for sampling/driving
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ci  = 1'b0;
    #1;
    check("reset_q", {24'h0, q}, 32'h00);
    check("reset_co", {31'h0, co}, 32'h0);
    ci = 1'b1;
    #1;
    check("reset_co_ci1", {31'h0, co}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    ci  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("count_q", {24'h0, q}, i);
      check("count_co", {31'h0, co}, 32'h0);
    end

    ci = 1'b0;
    step();
    check("hold_q", {24'h0, q}, 32'h05);
    check("hold_co", {31'h0, co}, 32'h0);
    ci = 1'b1;
    step();
    check("resume_q", {24'h0, q}, 32'h06);

    // ci glitch between edges must not count
    ci = 1'b0;
    #1 ci = 1'b1;
    #1 ci = 1'b0;
    step();
    check("glitch_q", {24'h0, q}, 32'h06);

    ci    = 1'b1;
    exp_q = 8'h06;
    while (exp_q != 8'hFE) begin
      step();
      exp_q = exp_q + 8'd1;
    end
    check("preset_q", {24'h0, q}, 32'hFE);
    check("preset_co", {31'h0, co}, 32'h0);
    step();
    check("full_q", {24'h0, q}, 32'hFF);
    check("full_co", {31'h0, co}, 32'h1);

    ci = 1'b0;
    #1;
    check("co_ci0", {31'h0, co}, 32'h0);
    check("q_ci0", {24'h0, q}, 32'hFF);
    ci = 1'b1;
    #1;
    check("co_ci1", {31'h0, co}, 32'h1);
    check("q_ci1", {24'h0, q}, 32'hFF);

    step();
    check("wrap_q", {24'h0, q}, 32'h00);
    check("wrap_co", {31'h0, co}, 32'h0);

    exp_q = 8'h00;
    while (exp_q != 8'h37) begin
      step();
      exp_q = exp_q + 8'd1;
    end
    check("mid_q", {24'h0, q}, 32'h37);

    #2 rst = 1'b1;
    #1;
    check("async_rst_q", {24'h0, q}, 32'h00);
    check("async_rst_co", {31'h0, co}, 32'h0);
    step();
    check("rst_hold_q", {24'h0, q}, 32'h00);
    rst = 1'b0;
    ci  = 1'b1;
    step();
    check("post_rst_q", {24'h0, q}, 32'h01);
    step();
    check("post_rst_q2", {24'h0, q}, 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
